mips_boot_loader: RTL and testbench
===================================

// Module: mips_boot_loader
// PURPOSE
//  Loads the single-cycle MIPS CPU's memories: instruction ROM, data RAM and register file.
//  Loading is driven by a valid/ready word stream plus an indexed-fill command.
//  After loading, the block sequences CPU reset, runs the CPU for a bounded cycle count, then halts it.
//  It sits between the stimulus source (bench or debug link) and the memory write ports and Reset of MIPSCPU.
// PARAMETERS
//  AW          10     memory word-address width (all channels)
//  DW          32     data word width
//  NCH         3      number of target memory channels (0=IMEM, 1=DMEM, 2=RF)
//  HOLD_CYC    2      cycles cpu_reset stays high after load completes (>=1)
//  RUN_CYC     10000  CPU run cycles before halt (>=1, <2^32)
//  FILL_DEPTH  32     words written by one fill command
//  FILL_STRIDE 4      fill data increment per address
// PORTS
//  Clk        in   1             system clock, rising edge
//  Reset      in   1             asynchronous, active-low reset
//  start      in   1             pulse; begins a load session (honoured in IDLE and DONE only)
//  in_valid   in   1             stream word valid
//  in_ready   out  1             stream word accepted when in_valid & in_ready
//  in_chan    in   $clog2(NCH)   target channel
//  in_fill    in   1             1: fill command (in_data = base), 0: single write
//  in_addr    in   AW            word address (ignored for fill)
//  in_data    in   DW            write data / fill base
//  in_last    in   1             final item of session
//  mem_we     out  NCH           one-hot write enable, one cycle per word
//  mem_addr   out  AW            write address
//  mem_wdata  out  DW            write data
//  cpu_reset  out  1             active-high reset to MIPSCPU
//  run_cnt    out  32            CPU cycles elapsed in RUN
//  busy       out  1             1 in LOAD/FILL/HOLD/RUN
//  done       out  1             1 in DONE
//  err        out  1             sticky error, cleared on start
// BEHAVIOUR
//  Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, run_cnt=0, busy=0, done=0, err=0. State=IDLE.
//  Reset mid-operation: all outputs return to reset values immediately (async); writes already issued stand.
//  States: IDLE -start-> LOAD; LOAD -fill-> FILL -count end-> LOAD (or HOLD if its in_last);
//    LOAD -last write-> HOLD -HOLD_CYC-> RUN -RUN_CYC-> DONE -start-> LOAD.
//  LOAD: in_ready=1. Accepted single write appears on mem_* the next cycle (latency 1), mem_we[in_chan]=1 for 1 cycle.
//  Back-to-back accepts give one write per cycle with no bubbles.
//  FILL: in_ready=0; for i=0..FILL_DEPTH-1 one write per cycle: addr=i mod 2^AW, data=(base+i*FILL_STRIDE) mod 2^DW.
//  in_chan>=NCH: item consumed, no write, err<=1; session continues. in_last on such an item still moves to HOLD.
//  HOLD: cpu_reset=1 for exactly HOLD_CYC cycles.
//  RUN: cpu_reset=0; run_cnt increments by 1 per cycle; on reaching RUN_CYC, go to DONE.
//  DONE: cpu_reset=1 (CPU frozen), done=1, run_cnt held.
//  start in DONE: clears run_cnt, done and err, then enters LOAD. start in any other non-IDLE state is ignored.
//  mem_we is never asserted outside LOAD/FILL. At most one bit of mem_we is set at any time.
// CONFIGURATION
//  MIPS_LOADER_CHECKSUM_EN defined: adds input exp_sum[DW] and output chk_sum[DW].
//    chk_sum is the mod-2^DW sum of every written word, including fill words. It is cleared on start.
//    On HOLD entry, chk_sum != exp_sum sets err=1 and goes straight to DONE; the CPU never runs.
//  Undefined: no exp_sum/chk_sum ports; err is set only by a bad channel.
// STRUCTURE
//  Package mips_loader_pkg holds: state enum typedef; channel constants CH_IMEM=0, CH_DMEM=1, CH_RF=2.
//  Sub-module loader_fill_gen provides the fill address counter and base+stride data generator, with a last flag.
// TESTING
//  1) 11 single IMEM writes (addr 0..10, last on 10) -> 11 we[0] pulses at latency 1; cpu_reset high 2 cycles after, then low.
//  2) Fill DMEM base 0, then fill RF base 0 with last -> 32 writes each, data 0,4,..,124; then HOLD.
//  3) RUN_CYC=20 -> run_cnt reaches 20, done=1, cpu_reset=1; start -> run_cnt=0, in_ready=1 next cycle.
//  4) in_chan=3 with NCH=3 -> mem_we stays 0, err=1; next valid write is still accepted.
//  5) Reset low mid-FILL at i=10 -> mem_we=0 and cpu_reset=1 immediately; IDLE after release.
//  6) CHECKSUM_EN, exp_sum wrong by 1 -> err=1, DONE without any cycle of cpu_reset=0.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS boot loader.
package mips_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FILL,
      S_HOLD,
      S_RUN,
      S_DONE
   } state_t;

   localparam int unsigned CH_IMEM = 0;
   localparam int unsigned CH_DMEM = 1;
   localparam int unsigned CH_RF   = 2;

   // Index width that never collapses to zero bits for a single channel.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/loader_fill_gen.sv
// Fill address counter and base+stride data generator for the boot loader.
module loader_fill_gen
   import mips_loader_pkg::*;
#(
   parameter int unsigned AW     = 10,
   parameter int unsigned DW     = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned STRIDE = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic          advance,
   input  logic [DW-1:0] base,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] data,
   output logic          last_c
);

   logic [31:0] cnt;

   // load restarts the sequence at index 0; advance steps to the next word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         data <= '0;
      end else if (load) begin
         cnt  <= '0;
         data <= base;
      end else if (advance) begin
         cnt  <= cnt + 32'd1;
         data <= data + DW'(STRIDE);
      end
   end

   assign addr   = AW'(cnt);
   assign last_c = (cnt == 32'(DEPTH - 1));

endmodule

// File: rtl/mips_boot_loader.sv
// Memory loader and reset/run sequencer for the single-cycle MIPS CPU.
// Optional MIPS_LOADER_CHECKSUM_EN adds exp_sum/chk_sum write-checksum gating of the run.
module mips_boot_loader
   import mips_loader_pkg::*;
#(
   parameter int unsigned AW          = 10,
   parameter int unsigned DW          = 32,
   parameter int unsigned NCH         = 3,
   parameter int unsigned HOLD_CYC    = 2,
   parameter int unsigned RUN_CYC     = 10000,
   parameter int unsigned FILL_DEPTH  = 32,
   parameter int unsigned FILL_STRIDE = 4
) (
   input  logic                        Clk,
   input  logic                        Reset,
   input  logic                        start,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [clog2_min1(NCH)-1:0]  in_chan,
   input  logic                        in_fill,
   input  logic [AW-1:0]               in_addr,
   input  logic [DW-1:0]               in_data,
   input  logic                        in_last,
`ifdef MIPS_LOADER_CHECKSUM_EN
   input  logic [DW-1:0]               exp_sum,
`endif
   output logic [NCH-1:0]              mem_we,
   output logic [AW-1:0]               mem_addr,
   output logic [DW-1:0]               mem_wdata,
   output logic                        cpu_reset,
   output logic [31:0]                 run_cnt,
   output logic                        busy,
   output logic                        done,
`ifdef MIPS_LOADER_CHECKSUM_EN
   output logic [DW-1:0]               chk_sum,
`endif
   output logic                        err
);

   localparam int unsigned CW = clog2_min1(NCH);

   state_t         state, state_d;
   logic           in_ready_d, cpu_reset_d, busy_d, done_d, err_d;
   logic [NCH-1:0] mem_we_d;
   logic [AW-1:0]  mem_addr_d;
   logic [DW-1:0]  mem_wdata_d;
   logic [31:0]    run_cnt_d, hold_cnt, hold_cnt_d;
   logic [CW-1:0]  fill_chan, fill_chan_d;
   logic           fill_last, fill_last_d;
   logic           fill_load_c, fill_adv_c, fill_last_c, chan_ok_c;
   logic [AW-1:0]  fill_addr;
   logic [DW-1:0]  fill_data;
`ifdef MIPS_LOADER_CHECKSUM_EN
   logic [DW-1:0]  chk_sum_d;
`endif

   assign chan_ok_c = (32'(in_chan) < NCH);

   loader_fill_gen #(
      .AW     (AW),
      .DW     (DW),
      .DEPTH  (FILL_DEPTH),
      .STRIDE (FILL_STRIDE)
   ) u_fill (
      .clk     (Clk),
      .rst_n   (Reset),
      .load    (fill_load_c),
      .advance (fill_adv_c),
      .base    (in_data),
      .addr    (fill_addr),
      .data    (fill_data),
      .last_c  (fill_last_c)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= S_IDLE;
         in_ready  <= 1'b0;
         mem_we    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         cpu_reset <= 1'b1;
         run_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         hold_cnt  <= '0;
         fill_chan <= '0;
         fill_last <= 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
         chk_sum   <= '0;
`endif
      end else begin
         state     <= state_d;
         in_ready  <= in_ready_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         cpu_reset <= cpu_reset_d;
         run_cnt   <= run_cnt_d;
         busy      <= busy_d;
         done      <= done_d;
         err       <= err_d;
         hold_cnt  <= hold_cnt_d;
         fill_chan <= fill_chan_d;
         fill_last <= fill_last_d;
`ifdef MIPS_LOADER_CHECKSUM_EN
         chk_sum   <= chk_sum_d;
`endif
      end
   end

   // Next state plus next values of every registered output
   always_comb begin
      state_d     = state;
      mem_we_d    = '0;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      run_cnt_d   = run_cnt;
      err_d       = err;
      hold_cnt_d  = hold_cnt;
      fill_chan_d = fill_chan;
      fill_last_d = fill_last;
      fill_load_c = 1'b0;
      fill_adv_c  = 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
      chk_sum_d   = chk_sum;
`endif

      case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_LOAD;
               run_cnt_d = '0;
               err_d     = 1'b0;
`ifdef MIPS_LOADER_CHECKSUM_EN
               chk_sum_d = '0;
`endif
            end
         end
         S_LOAD: begin
            hold_cnt_d = '0;
            if (in_valid && in_ready) begin
               if (!chan_ok_c) begin
                  err_d = 1'b1;
                  if (in_last) state_d = S_HOLD;
               end else if (in_fill) begin
                  fill_load_c = 1'b1;
                  fill_chan_d = in_chan;
                  fill_last_d = in_last;
                  state_d     = S_FILL;
               end else begin
                  mem_we_d    = NCH'(1) << in_chan;
                  mem_addr_d  = in_addr;
                  mem_wdata_d = in_data;
                  if (in_last) state_d = S_HOLD;
               end
            end
         end
         S_FILL: begin
            hold_cnt_d  = '0;
            fill_adv_c  = 1'b1;
            mem_we_d    = NCH'(1) << fill_chan;
            mem_addr_d  = fill_addr;
            mem_wdata_d = fill_data;
            if (fill_last_c) state_d = fill_last ? S_HOLD : S_LOAD;
         end
         S_HOLD: begin
            if (hold_cnt == 32'(HOLD_CYC - 1)) state_d = S_RUN;
            else hold_cnt_d = hold_cnt + 32'd1;
`ifdef MIPS_LOADER_CHECKSUM_EN
            // Checked on the first HOLD cycle, once the last write has been summed
            if (hold_cnt == '0 && chk_sum != exp_sum) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
`endif
         end
         S_RUN: begin
            run_cnt_d = run_cnt + 32'd1;
            if (run_cnt_d == 32'(RUN_CYC)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef MIPS_LOADER_CHECKSUM_EN
      if (|mem_we_d) chk_sum_d = chk_sum_d + mem_wdata_d;
`endif

      in_ready_d  = (state_d == S_LOAD);
      cpu_reset_d = (state_d != S_RUN);
      done_d      = (state_d == S_DONE);
      busy_d      = (state_d == S_LOAD) || (state_d == S_FILL) ||
                    (state_d == S_HOLD) || (state_d == S_RUN);
   end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: random data against a write-list model.
module tb_mips_boot_loader;
   import mips_loader_pkg::*;

   localparam int unsigned AW = 10, DW = 32, NCH = 3, HOLD = 2, RUN = 20;
   localparam int unsigned DEPTH = 32, STRIDE = 4;

   logic          Clk = 1'b0, Reset = 1'b1, start = 1'b0, in_valid = 1'b0;
   logic          in_fill = 1'b0, in_last = 1'b0;
   logic [1:0]    in_chan = '0;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, cpu_reset, busy, done, err;
   logic [2:0]    mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [31:0]   run_cnt;
   logic [31:0]   msum = '0;
   int            bias = 0;
`ifdef MIPS_LOADER_CHECKSUM_EN
   logic [DW-1:0] exp_sum, chk_sum;
   assign exp_sum = msum + 32'(bias);
`endif

   mips_boot_loader #(
      .AW(AW), .DW(DW), .NCH(NCH), .HOLD_CYC(HOLD), .RUN_CYC(RUN),
      .FILL_DEPTH(DEPTH), .FILL_STRIDE(STRIDE)
   ) dut (
      .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_chan(in_chan), .in_fill(in_fill), .in_addr(in_addr), .in_data(in_data),
      .in_last(in_last),
`ifdef MIPS_LOADER_CHECKSUM_EN
      .exp_sum(exp_sum),
`endif
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_reset(cpu_reset), .run_cnt(run_cnt), .busy(busy), .done(done),
`ifdef MIPS_LOADER_CHECKSUM_EN
      .chk_sum(chk_sum),
`endif
      .err(err)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc++;

   typedef struct {int chan; int addr; logic [31:0] data; int cyc;} wr_t;
   wr_t obs_q[$];
   wr_t exp_q[$];
   int  bad_onehot = 0;
   int  total = 0, npass = 0;

   // Record every memory write seen on the bus
   always @(negedge Clk) begin : mon
      wr_t w;
      if (mem_we != 3'b000) begin
         w.chan = (mem_we == 3'b001) ? 0 : (mem_we == 3'b010) ? 1 :
                  (mem_we == 3'b100) ? 2 : -1;
         if (w.chan < 0) bad_onehot++;
         w.addr = 32'(mem_addr);
         w.data = mem_wdata;
         w.cyc  = cyc;
         obs_q.push_back(w);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic model_single(input int chan, input int addr, input logic [31:0] data);
      wr_t w;
      if (chan < int'(NCH)) begin
         w.chan = chan; w.addr = addr; w.data = data; w.cyc = 0;
         exp_q.push_back(w);
         msum += data;
      end
   endtask

   task automatic model_fill(input int chan, input logic [31:0] base, input int count);
      for (int i = 0; i < count; i++)
         model_single(chan, i % (1 << AW), base + 32'(i) * 32'(STRIDE));
   endtask

   task automatic compare_writes(input string tag);
      chk($sformatf("%s.count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk($sformatf("%s[%0d].chan", tag, i), obs_q[i].chan, exp_q[i].chan);
         chk($sformatf("%s[%0d].addr", tag, i), obs_q[i].addr, exp_q[i].addr);
         chk($sformatf("%s[%0d].data", tag, i), obs_q[i].data, exp_q[i].data);
      end
   endtask

   task automatic new_session();
      obs_q.delete(); exp_q.delete(); msum = '0;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 100) begin step(); n++; end
      if (!in_ready) chk("ready_timeout", 32'(in_ready), 1);
   endtask

   task automatic send(input int chan, input bit fill, input int addr,
                       input logic [31:0] data, input bit last);
      wait_ready();
      in_valid = 1'b1; in_chan = 2'(chan); in_fill = fill;
      in_addr = 10'(addr); in_data = data; in_last = last;
      step();
      in_valid = 1'b0; in_fill = 1'b0; in_last = 1'b0;
   endtask

   // Count run cycles (cpu_reset low) from now until done, optionally poking start once
   task automatic wait_done(input bit pulse, output int n);
      int k = 0;
      n = 0;
      while (!done && k < 400) begin
         if (!cpu_reset) n++;
         start = pulse && (k == 0);
         step();
         start = 1'b0;
         k++;
      end
      if (!done) chk("done_timeout", 32'(done), 1);
   endtask

   initial begin
      int k0, nrun, found;
      logic [31:0] d, base;

      // Reset values
      #1 Reset = 1'b0;
      #10;
      chk("rst.in_ready", 32'(in_ready), 0);
      chk("rst.mem_we", 32'(mem_we), 0);
      chk("rst.mem_addr", 32'(mem_addr), 0);
      chk("rst.mem_wdata", mem_wdata, 0);
      chk("rst.cpu_reset", 32'(cpu_reset), 1);
      chk("rst.run_cnt", run_cnt, 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.done", 32'(done), 0);
      chk("rst.err", 32'(err), 0);
      @(negedge Clk) Reset = 1'b1;
      step();
      chk("idle.in_ready", 32'(in_ready), 0);

      // 1) back-to-back IMEM writes, HOLD window, then RUN to DONE
      new_session();
      chk("t1.in_ready", 32'(in_ready), 1);
      chk("t1.busy", 32'(busy), 1);
      k0 = cyc;
      for (int j = 0; j <= 10; j++) begin
         d = $urandom;
         in_valid = 1'b1; in_chan = 2'(CH_IMEM); in_fill = 1'b0;
         in_addr = 10'(j); in_data = d; in_last = (j == 10);
         model_single(int'(CH_IMEM), j, d);
         step();
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("t1.hold0.cpu_reset", 32'(cpu_reset), 1);
      step();
      chk("t1.hold1.cpu_reset", 32'(cpu_reset), 1);
      step();
      chk("t1.run.cpu_reset", 32'(cpu_reset), 0);
      wait_done(1'b1, nrun);
      chk("t1.run_cycles", nrun, RUN);
      compare_writes("t1");
      for (int j = 0; j < obs_q.size() && j < 11; j++)
         chk($sformatf("t1.latency[%0d]", j), obs_q[j].cyc, k0 + 1 + j);

      // 3) DONE state and restart
      chk("t3.run_cnt", run_cnt, RUN);
      chk("t3.done", 32'(done), 1);
      chk("t3.cpu_reset", 32'(cpu_reset), 1);
      chk("t3.busy", 32'(busy), 0);
      step(); step();
      chk("t3.run_cnt_held", run_cnt, RUN);

      // 2) fill DMEM from base 0, then fill RF from a random base with last
      new_session();
      chk("t3.restart.run_cnt", run_cnt, 0);
      chk("t3.restart.in_ready", 32'(in_ready), 1);
      chk("t3.restart.done", 32'(done), 0);
      send(int'(CH_DMEM), 1'b1, $urandom_range(0, 1023), 32'd0, 1'b0);
      model_fill(int'(CH_DMEM), 32'd0, DEPTH);
      base = $urandom;
      send(int'(CH_RF), 1'b1, 0, base, 1'b1);
      model_fill(int'(CH_RF), base, DEPTH);
      wait_done(1'b0, nrun);
      chk("t2.run_cycles", nrun, RUN);
      compare_writes("t2");
      if (obs_q.size() >= 64) begin
         chk("t2.burst0", obs_q[31].cyc - obs_q[0].cyc, 31);
         chk("t2.burst1", obs_q[63].cyc - obs_q[32].cyc, 31);
      end
`ifdef MIPS_LOADER_CHECKSUM_EN
      chk("t2.chk_sum", chk_sum, msum);
`endif

      // 4) bad channel: consumed, no write, sticky err; session continues
      new_session();
      send(3, 1'b0, $urandom_range(0, 1023), $urandom, 1'b0);
      step();
      chk("t4.err", 32'(err), 1);
      chk("t4.no_write", 32'(obs_q.size()), 0);
      chk("t4.in_ready", 32'(in_ready), 1);
      k0 = $urandom_range(0, 1023); d = $urandom;
      send(int'(CH_RF), 1'b0, k0, d, 1'b1);
      model_single(int'(CH_RF), k0, d);
      wait_done(1'b0, nrun);
      compare_writes("t4");
      chk("t4.err_sticky", 32'(err), 1);
      new_session();
      chk("t4.err_cleared", 32'(err), 0);
      send(3, 1'b1, 0, $urandom, 1'b1);
      wait_done(1'b0, nrun);
      chk("t4.last_bad.run_cycles", nrun, RUN);
      chk("t4.last_bad.err", 32'(err), 1);
      chk("t4.last_bad.writes", 32'(obs_q.size()), 0);

      // 5) reset asserted in the middle of a fill
      new_session();
      base = $urandom;
      send(int'(CH_DMEM), 1'b1, 0, base, 1'b0);
      model_fill(int'(CH_DMEM), base, 11);
      found = 0;
      for (int n = 0; n < 100 && found == 0; n++) begin
         if (mem_we != 3'b000 && mem_addr == 10'd10) found = 1;
         else step();
      end
      chk("t5.reached_i10", found, 1);
      #1 Reset = 1'b0;
      #1;
      chk("t5.mem_we", 32'(mem_we), 0);
      chk("t5.cpu_reset", 32'(cpu_reset), 1);
      chk("t5.busy", 32'(busy), 0);
      chk("t5.in_ready", 32'(in_ready), 0);
      @(negedge Clk) Reset = 1'b1;
      step();
      chk("t5.idle.in_ready", 32'(in_ready), 0);
      chk("t5.idle.busy", 32'(busy), 0);
      compare_writes("t5");

`ifdef MIPS_LOADER_CHECKSUM_EN
      // 6) checksum off by one: straight to DONE, CPU never released
      new_session();
      for (int j = 0; j < 3; j++) begin
         d = $urandom;
         send(int'(CH_DMEM), 1'b0, j, d, j == 2);
         model_single(int'(CH_DMEM), j, d);
      end
      bias = 1;
      wait_done(1'b0, nrun);
      chk("t6.run_cycles", nrun, 0);
      chk("t6.err", 32'(err), 1);
      chk("t6.done", 32'(done), 1);
      chk("t6.run_cnt", run_cnt, 0);
      chk("t6.chk_sum", chk_sum, msum);
      bias = 0;
`else
      new_session();
      chk("t6.idle_start.in_ready", 32'(in_ready), 1);
`endif

      chk("onehot", bad_onehot, 0);
      $display("%0d/%0d checks passed", npass, total);
      $finish;
   end

endmodule
